// File: rtl/sha512_pkg.sv
// Shared constants and state encoding for the SHA-512 message padder.
package sha512_pkg;
    localparam int WORD_W      = 64;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_W     = 1024;
    localparam int LEN_FIELD_W = 128;
    localparam logic [7:0]        PAD_BYTE = 8'h80;
    localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 56'h0};

    typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_EMIT} pad_state_t;
endpackage

// File: rtl/sha512_pad_lastword.sv
// Final-word shaping: keeps the first nbytes bytes (MSB-aligned), puts 0x80 at byte nbytes.
// nbytes >= 8 passes the word through untouched.
module sha512_pad_lastword
    import sha512_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    input  logic [3:0]        nbytes,
    output logic [WORD_W-1:0] word
);
    always_comb begin
        word = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes)
                word[WORD_W-1-8*i -: 8] = data[WORD_W-1-8*i -: 8];
            else if (4'(i) == nbytes)
                word[WORD_W-1-8*i -: 8] = PAD_BYTE;
        end
    end
endmodule

// File: rtl/sha512_msg_padder.sv
// SHA-512 padder: 64-bit word stream in, padded 1024-bit blocks out.
// SHA512_PAD_BSWAP_EN: byte-reverse in_data on entry for a little-endian host bus.
module sha512_msg_padder
    import sha512_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [3:0]         in_nbytes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               out_first,
    output logic               out_last,
    output logic               busy
);
    pad_state_t state_q, state_d;
    logic [4:0]       widx_q, widx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    // Ascending packed range so word 0 sits in the MSBs of out_block.
    logic [0:BLOCK_WORDS-1][WORD_W-1:0] blk_q, blk_d;
    logic pad_pending_q, pad_pending_d;
    logic post_emit_q, post_emit_d;
    logic first_armed_q, first_armed_d;
    logic out_last_q, out_last_d;
    logic busy_q, busy_d;

    logic [WORD_W-1:0]      in_word, shaped_word;
    logic [3:0]             nb_eff, nb_word;
    logic [LEN_FIELD_W-1:0] len_bits;

`ifdef SHA512_PAD_BSWAP_EN
    always_comb begin
        in_word = '0;
        for (int i = 0; i < 8; i++)
            in_word[8*i +: 8] = in_data[WORD_W-8-8*i +: 8];
    end
`else
    assign in_word = in_data;
`endif

    assign nb_eff   = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    assign nb_word  = in_last ? nb_eff : 4'd8;
    assign len_bits = LEN_FIELD_W'(cnt_q) << 3;

    sha512_pad_lastword u_lastword (
        .data   (in_word),
        .nbytes (nb_word),
        .word   (shaped_word)
    );

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        cnt_d         = cnt_q;
        blk_d         = blk_q;
        pad_pending_d = pad_pending_q;
        post_emit_d   = post_emit_q;
        first_armed_d = first_armed_q;
        out_last_d    = out_last_q;
        busy_d        = busy_q;
        case (state_q)
            S_FILL: if (in_valid) begin
                blk_d[widx_q[3:0]] = shaped_word;
                widx_d = widx_q + 5'd1;
                cnt_d  = cnt_q + LEN_W'(nb_word);
                busy_d = 1'b1;
                if (!in_last) begin
                    if (widx_d == 5'd16) begin
                        state_d    = S_EMIT;
                        out_last_d = 1'b0;
                    end
                end else if (nb_eff == 4'd8) begin
                    pad_pending_d = 1'b1;
                    state_d       = S_PAD;
                end else begin
                    state_d = (widx_d <= 5'd14) ? S_LEN : S_PAD;
                end
            end
            S_PAD: begin
                // A full buffer has no slot for the pad word; flush it and continue after.
                if (widx_q[4]) begin
                    state_d     = S_EMIT;
                    out_last_d  = 1'b0;
                    post_emit_d = 1'b1;
                end else begin
                    blk_d[widx_q[3:0]] = pad_pending_q ? PAD_WORD : '0;
                    pad_pending_d = 1'b0;
                    widx_d = widx_q + 5'd1;
                    if (widx_d == 5'd14) begin
                        state_d = S_LEN;
                    end else if (widx_d == 5'd16) begin
                        state_d     = S_EMIT;
                        out_last_d  = 1'b0;
                        post_emit_d = 1'b1;
                    end
                end
            end
            S_LEN: begin
                for (int i = 0; i < 14; i++)
                    if (5'(i) >= widx_q) blk_d[i] = '0;
                blk_d[14]  = len_bits[127:64];
                blk_d[15]  = len_bits[63:0];
                widx_d     = 5'd16;
                state_d    = S_EMIT;
                out_last_d = 1'b1;
            end
            S_EMIT: if (out_ready) begin
                blk_d         = '0;
                widx_d        = 5'd0;
                state_d       = post_emit_q ? S_PAD : S_FILL;
                post_emit_d   = 1'b0;
                first_armed_d = out_last_q;
                out_last_d    = 1'b0;
                if (out_last_q) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FILL;
            widx_q        <= '0;
            cnt_q         <= '0;
            blk_q         <= '0;
            pad_pending_q <= 1'b0;
            post_emit_q   <= 1'b0;
            first_armed_q <= 1'b1;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            cnt_q         <= cnt_d;
            blk_q         <= blk_d;
            pad_pending_q <= pad_pending_d;
            post_emit_q   <= post_emit_d;
            first_armed_q <= first_armed_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
        end
    end

    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_EMIT);
    assign out_block = blk_q;
    assign out_first = out_valid && first_armed_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sha512_msg_padder.sv
// Bench for sha512_msg_padder: byte-level FIPS 180-4 padding model, directed and random messages.
module tb_sha512_msg_padder;
    logic          clock = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [63:0]   in_data = '0;
    logic [3:0]    in_nbytes = '0;
    logic          in_ready, out_valid, out_first, out_last, busy;
    logic [1023:0] out_block;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    sha512_msg_padder dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    logic [1023:0] exp_blk_q[$];
    logic          exp_first_q[$], exp_last_q[$];
    logic [63:0]   wd_q[$];
    logic          wl_q[$];
    logic [3:0]    wn_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pads the message as a byte string, cuts 128-byte blocks, and queues the input words.
    task automatic add_msg(input byte unsigned msg[$], input bit full_last);
        byte unsigned p[$];
        longint unsigned bits;
        int nblk, nw, rem;
        bit lastfull;
        logic [63:0] w;
        p = msg;
        bits = 64'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 128 != 112) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8*i)));
        nblk = p.size() / 128;
        for (int b = 0; b < nblk; b++) begin
            logic [1023:0] blk;
            for (int k = 0; k < 128; k++) blk[1023-8*k -: 8] = p[128*b+k];
            exp_blk_q.push_back(blk);
            exp_first_q.push_back(b == 0);
            exp_last_q.push_back(b == nblk-1);
        end
        nw = msg.size() / 8;
        rem = msg.size() % 8;
        lastfull = (rem == 0) && (nw > 0) && full_last;
        for (int i = 0; i < nw; i++) begin
            for (int k = 0; k < 8; k++) w[63-8*k -: 8] = msg[8*i+k];
            wd_q.push_back(w);
            wl_q.push_back(lastfull && i == nw-1);
            wn_q.push_back((lastfull && i == nw-1) ? 4'(8 + $urandom_range(7)) : 4'($urandom_range(15)));
        end
        if (!lastfull) begin
            w = {$urandom, $urandom};
            for (int k = 0; k < rem; k++) w[63-8*k -: 8] = msg[8*nw+k];
            wd_q.push_back(w);
            wl_q.push_back(1'b1);
            wn_q.push_back(4'(rem));
        end
    endtask

    // Streams queued words and compares every accepted block against the model.
    task automatic run(input bit rnd);
        int cyc = 0, nblk = 0;
        bit stall = 0;
        logic [1023:0] hold = '0;
        while ((wd_q.size() > 0 || exp_blk_q.size() > 0) && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_blk", 64'(out_block == hold), 64'd1);
            end
            in_valid = (wd_q.size() > 0) && (!rnd || $urandom_range(3) != 0);
            if (wd_q.size() > 0) begin
                in_data = wd_q[0]; in_last = wl_q[0]; in_nbytes = wn_q[0];
            end
            out_ready = !rnd || $urandom_range(2) != 0;
            if (in_valid && in_ready) begin
                void'(wd_q.pop_front()); void'(wl_q.pop_front()); void'(wn_q.pop_front());
            end
            if (out_valid && out_ready) begin
                chk("blk_expected", 64'(exp_blk_q.size() > 0), 64'd1);
                if (exp_blk_q.size() > 0) begin
                    for (int w = 0; w < 16; w++)
                        chk($sformatf("b%0d_w%0d", nblk, w), out_block[1023-64*w -: 64],
                            exp_blk_q[0][1023-64*w -: 64]);
                    chk($sformatf("b%0d_first", nblk), 64'(out_first), 64'(exp_first_q[0]));
                    chk($sformatf("b%0d_last", nblk), 64'(out_last), 64'(exp_last_q[0]));
                    void'(exp_blk_q.pop_front()); void'(exp_first_q.pop_front());
                    void'(exp_last_q.pop_front());
                end
                nblk++;
            end
            stall = out_valid && !out_ready;
            hold = out_block;
        end
        chk("run_in_time", 64'(cyc < 20000), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic put_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = nb;
        while (!in_ready && n < 100) begin @(negedge clock); n++; end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        byte unsigned m[$];
        logic [1023:0] hold;
        int n;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_first", 64'(out_first), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_block", 64'(|out_block), 64'd0);
        reset = 1'b0;

        m = {8'h61, 8'h62, 8'h63};
        add_msg(m, 1'b0); run(1'b0);
        m.delete();
        add_msg(m, 1'b0); run(1'b0);
        for (int i = 0; i < 112; i++) m.push_back(8'($urandom));
        add_msg(m, 1'b1); run(1'b0);
        m.delete();
        for (int i = 0; i < 111; i++) m.push_back(8'($urandom));
        add_msg(m, 1'b0); run(1'b0);

        // Backpressure on "abc": block must sit still until accepted.
        @(negedge clock);
        out_ready = 1'b0;
        put_word(64'h6162_6300_dead_beef, 1'b1, 4'd3);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clock); n++; end
        chk("t5_valid", 64'(out_valid), 64'd1);
        chk("t5_w0", out_block[1023:960], 64'h6162_6380_0000_0000);
        chk("t5_w15", out_block[63:0], 64'h18);
        hold = out_block;
        repeat (5) begin
            chk("t5_in_ready", 64'(in_ready), 64'd0);
            chk("t5_stable", 64'(out_block == hold), 64'd1);
            @(negedge clock);
        end
        out_ready = 1'b1;
        chk("t5_first", 64'(out_first), 64'd1);
        chk("t5_last", 64'(out_last), 64'd1);
        @(negedge clock);
        out_ready = 1'b0;
        chk("t5_taken", 64'(out_valid), 64'd0);
        chk("t5_in_ready_after", 64'(in_ready), 64'd1);

        // Reset while padding the 112-byte message, then a clean "abc".
        for (int i = 0; i < 14; i++) put_word({$urandom, $urandom}, i == 13, 4'd8);
        chk("t6_busy_pad", 64'(busy), 64'd1);
        chk("t6_in_ready_pad", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        m = {8'h61, 8'h62, 8'h63};
        add_msg(m, 1'b0); run(1'b0);

        // Random back-to-back messages with gaps and backpressure.
        for (int j = 0; j < 25; j++) begin
            m.delete();
            n = $urandom_range(300);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            add_msg(m, 1'($urandom));
        end
        run(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
